// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter that shares the write port of fifo_async between requesters.
// Acks and FIFO write strobes are combinational so a grant costs no added latency.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_WIDTH = 16,
  localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] wdata_i,
  input  logic                     full_i,
  input  logic                     wr_error_i,
  output logic [NUM_REQ-1:0]       ack_o,
  output logic                     fifo_wr_en_o,
  output logic [WIDTH-1:0]         fifo_wdata_o,
  output logic [IDW-1:0]           owner_o,
  output logic                     busy_o,
  output logic [CNT_WIDTH-1:0]     xfer_cnt_o,
  output logic [CNT_WIDTH-1:0]     err_cnt_o
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, HOLD = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr, rr_nxt;
  logic [IDW-1:0]   owner, owner_nxt;
  logic [BW-1:0]    beat_cnt, beat_nxt, beat_inc;
  logic [CNT_WIDTH-1:0] xfer_cnt, err_cnt;
  logic             cand_found;
  logic [IDW-1:0]   cand;
  logic             grant;
  logic [IDW-1:0]   grant_idx;

  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    return (sum >= NUM_REQ) ? IDW'(sum - NUM_REQ) : IDW'(sum);
  endfunction

  // First requester at or after rr_ptr, wrapping NUM_REQ-1 -> 0
  always_comb begin
    cand_found = 1'b0;
    cand       = {IDW{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!cand_found && req_i[rr_index(rr_ptr, i)]) begin
        cand_found = 1'b1;
        cand       = rr_index(rr_ptr, i);
      end else begin
        cand_found = cand_found;
      end
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      rr_ptr   <= {IDW{1'b0}};
      owner    <= {IDW{1'b0}};
      beat_cnt <= {BW{1'b0}};
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  // Next-state and grant decision; BURST and HOLD share the same owner rules
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    beat_nxt  = beat_cnt;
    grant     = 1'b0;
    grant_idx = owner;
    beat_inc  = beat_cnt + BW'(1);
    case (state)
      IDLE: begin
        if (cand_found) begin
          owner_nxt = cand;
          grant_idx = cand;
          if (!full_i) begin
            grant    = 1'b1;
            beat_nxt = BW'(1);
            if (MAX_BURST == 1) begin
              state_nxt = IDLE;
              rr_nxt    = rr_index(cand, 1);
            end else begin
              state_nxt = BURST;
            end
          end else begin
            beat_nxt  = {BW{1'b0}};
            state_nxt = HOLD;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      BURST, HOLD: begin
        if (!req_i[owner]) begin
          state_nxt = IDLE;
          rr_nxt    = rr_index(owner, 1);
        end else if (full_i) begin
          state_nxt = HOLD;
        end else begin
          grant    = 1'b1;
          beat_nxt = beat_inc;
          if (beat_inc == BW'(MAX_BURST)) begin
            state_nxt = IDLE;
            rr_nxt    = rr_index(owner, 1);
          end else begin
            state_nxt = BURST;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Handshake and FIFO write outputs, held off while reset is asserted
  always_comb begin
    ack_o        = {NUM_REQ{1'b0}};
    fifo_wdata_o = {WIDTH{1'b0}};
    if (grant && !rst_i) begin
      ack_o[grant_idx] = 1'b1;
      fifo_wdata_o     = wdata_i[int'(grant_idx)*WIDTH +: WIDTH];
    end else begin
      ack_o        = {NUM_REQ{1'b0}};
      fifo_wdata_o = {WIDTH{1'b0}};
    end
  end

  assign fifo_wr_en_o = |ack_o;
  assign owner_o      = owner;
  assign busy_o       = (state != IDLE);

  // Saturating debug counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      xfer_cnt <= {CNT_WIDTH{1'b0}};
      err_cnt  <= {CNT_WIDTH{1'b0}};
    end else begin
      if (fifo_wr_en_o && (xfer_cnt != CNT_MAX)) begin
        xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
      end else begin
        xfer_cnt <= xfer_cnt;
      end
      if (wr_error_i && (err_cnt != CNT_MAX)) begin
        err_cnt <= err_cnt + CNT_WIDTH'(1);
      end else begin
        err_cnt <= err_cnt;
      end
    end
  end

  assign xfer_cnt_o = xfer_cnt;
  assign err_cnt_o  = err_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: cycle table for arbitration corners plus requester-driven
// sequences; written data is checked against a scoreboard queue.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic        full;
  logic        err;

  logic [3:0]  ack, ack_s;
  logic        wr_en, wr_en_s;
  logic [7:0]  wdo, wdo_s;
  logic [1:0]  owner, owner_s;
  logic        busy, busy_s;
  logic [15:0] xfer, errc;
  logic [3:0]  xfer_s, errc_s;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(8), .MAX_BURST(4), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .wdata_i(wdata), .full_i(full),
    .wr_error_i(err), .ack_o(ack), .fifo_wr_en_o(wr_en), .fifo_wdata_o(wdo),
    .owner_o(owner), .busy_o(busy), .xfer_cnt_o(xfer), .err_cnt_o(errc)
  );

  // Narrow-counter instance sharing all inputs, used for saturation
  fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(8), .MAX_BURST(4), .CNT_WIDTH(4)) dut_s (
    .clk_i(clk), .rst_i(rst), .req_i(req), .wdata_i(wdata), .full_i(full),
    .wr_error_i(err), .ack_o(ack_s), .fifo_wr_en_o(wr_en_s), .fifo_wdata_o(wdo_s),
    .owner_o(owner_s), .busy_o(busy_s), .xfer_cnt_o(xfer_s), .err_cnt_o(errc_s)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       full;
    logic       err;
    logic [3:0] ack;
    logic       chk;
    logic       busy;
    logic [1:0] owner;
    int         xfer;
    int         errc;
  } vec_t;

  vec_t       vq[$];
  logic [7:0] sb_q[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] src_q[$];
  int         src_id;
  logic       acked;

  function automatic vec_t mk(logic r, logic [3:0] q, logic f, logic e, logic [3:0] a,
                              logic c, logic b, logic [1:0] o, int x, int ec);
    vec_t v;
    v.rst = r; v.req = q; v.full = f; v.err = e; v.ack = a;
    v.chk = c; v.busy = b; v.owner = o; v.xfer = x; v.errc = ec;
    return v;
  endfunction

  function automatic int sat15(int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_write(string tag);
    logic [7:0] e;
    if (wr_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL %s unexpected write: data %0h, scoreboard empty", tag, wdo);
      end else begin
        e = sb_q.pop_front();
        check({tag, " wdata"}, 32'(wdo), 32'(e));
      end
    end else begin
      check({tag, " idle wdata"}, 32'(wdo), 32'h0);
    end
  endtask

  // One requester drains its queue; expects n back-to-back writes starting now
  task automatic run_src(int id, int n, logic [7:0] base, int cycles, string tag);
    src_id = id;
    for (int i = 0; i < n; i++) begin
      src_q.push_back(base + 8'(i));
      sb_q.push_back(base + 8'(i));
    end
    acked = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (acked && src_q.size() != 0) src_q.pop_front();
      rst = 1'b0; full = 1'b0; err = 1'b0;
      wdata = 32'h0;
      if (src_q.size() != 0) begin
        req = 4'(1 << src_id);
        wdata[src_id*8 +: 8] = src_q[0];
      end else begin
        req = 4'h0;
      end
      #3;
      check({tag, " wr_en"}, 32'(wr_en), 32'(c < n));
      check_write(tag);
      acked = ack[src_id];
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'h0; full = 1'b0; err = 1'b0; wdata = 32'hA3A2A1A0;

    // Reset with all requesting: no acks, cleared state
    vq.push_back(mk(1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 0, 0));
    vq.push_back(mk(1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 0, 0));
    // Fairness: four beats each for 0,1,2,3 with no gap across releases
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 4; b++) begin
        vq.push_back(mk(1'b0, 4'hF, 1'b0, 1'b0, 4'(1 << k), 1'b1, (b != 0),
                        (b != 0) ? 2'(k) : ((k == 0) ? 2'd0 : 2'(k - 1)), 4*k + b, 0));
      end
    end
    vq.push_back(mk(1'b0, 4'hF, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 2'd3, 16, 0));
    vq.push_back(mk(1'b0, 4'hF, 1'b0, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0, 17, 0));
    // Reset mid-burst aborts, priority restarts at 0
    vq.push_back(mk(1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 2'd0, 18, 0));
    vq.push_back(mk(1'b1, 4'h4, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 0, 0));
    // Full stall on requester 2 with 3 waiting
    vq.push_back(mk(1'b0, 4'h4, 1'b0, 1'b0, 4'h4, 1'b1, 1'b0, 2'd0, 0, 0));
    vq.push_back(mk(1'b0, 4'hC, 1'b0, 1'b0, 4'h4, 1'b1, 1'b1, 2'd2, 1, 0));
    vq.push_back(mk(1'b0, 4'hC, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 2'd2, 2, 0));
    vq.push_back(mk(1'b0, 4'hC, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 2'd2, 2, 0));
    vq.push_back(mk(1'b0, 4'hC, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 2'd2, 2, 0));
    vq.push_back(mk(1'b0, 4'hC, 1'b0, 1'b0, 4'h4, 1'b1, 1'b1, 2'd2, 2, 0));
    vq.push_back(mk(1'b0, 4'hC, 1'b0, 1'b0, 4'h4, 1'b1, 1'b1, 2'd2, 3, 0));
    vq.push_back(mk(1'b0, 4'hC, 1'b0, 1'b0, 4'h8, 1'b1, 1'b0, 2'd2, 4, 0));
    // Early drops: bubble then next candidate, skipping idle requesters
    vq.push_back(mk(1'b0, 4'h1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 2'd3, 5, 0));
    vq.push_back(mk(1'b0, 4'h9, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 2'd3, 5, 0));
    vq.push_back(mk(1'b0, 4'h9, 1'b0, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0, 6, 0));
    vq.push_back(mk(1'b0, 4'h8, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 2'd0, 7, 0));
    vq.push_back(mk(1'b0, 4'h8, 1'b0, 1'b0, 4'h8, 1'b1, 1'b0, 2'd0, 7, 0));
    vq.push_back(mk(1'b0, 4'h8, 1'b0, 1'b0, 4'h8, 1'b1, 1'b1, 2'd3, 8, 0));
    // Write-error pulses, one during an ack
    vq.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 2'd3, 9, 0));
    vq.push_back(mk(1'b0, 4'h1, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 2'd3, 9, 1));
    vq.push_back(mk(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 2'd0, 10, 2));
    vq.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 2'd0, 10, 2));
    vq.push_back(mk(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 10, 3));

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      rst = vq[i].rst; req = vq[i].req; full = vq[i].full; err = vq[i].err;
      for (int k = 0; k < 4; k++) begin
        if (vq[i].ack[k]) sb_q.push_back(8'hA0 + 8'(k));
      end
      #3;
      check($sformatf("row%0d ack", i), 32'(ack), 32'(vq[i].ack));
      check($sformatf("row%0d wr_en", i), 32'(wr_en), 32'(|vq[i].ack));
      check_write($sformatf("row%0d", i));
      if (vq[i].chk) begin
        check($sformatf("row%0d busy", i), 32'(busy), 32'(vq[i].busy));
        check($sformatf("row%0d owner", i), 32'(owner), 32'(vq[i].owner));
        check($sformatf("row%0d xfer_cnt", i), 32'(xfer), 32'(vq[i].xfer));
        check($sformatf("row%0d err_cnt", i), 32'(errc), 32'(vq[i].errc));
        check($sformatf("row%0d xfer_cnt sat", i), 32'(xfer_s), 32'(sat15(vq[i].xfer)));
        check($sformatf("row%0d err_cnt sat", i), 32'(errc_s), 32'(sat15(vq[i].errc)));
      end
    end

    // Single requester 1: six words, burst of 4 then immediate re-grant
    @(posedge clk);
    #1;
    rst = 1'b1; req = 4'h0; err = 1'b0; full = 1'b0;
    run_src(1, 6, 8'h11, 10, "single");
    check("single owner", 32'(owner), 32'd1);
    check("single xfer_cnt", 32'(xfer), 32'd6);
    check("single scoreboard drained", 32'(sb_q.size()), 32'd0);

    // Requester 0 adds 14 words: 20 writes total saturate the 4-bit counter
    run_src(0, 14, 8'h30, 18, "sat");
    check("sat xfer_cnt wide", 32'(xfer), 32'd20);
    check("sat xfer_cnt narrow", 32'(xfer_s), 32'd15);
    check("sat scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of the team's asynchronous FIFO (`fifo_async`) between several requesters in the write-clock domain. Each requester presents a word with a valid/ack handshake. The arbiter grants bursts of up to MAX_BURST words per owner, stalls on FIFO full, and drives the FIFO's write enable and write data combinationally. It also keeps saturating transfer and write-error counters for debug.

## Interface
- NUM_REQ, 4, number of requesters (≥2)
- WIDTH, 8, data width; matches the FIFO WIDTH
- MAX_BURST, 4, maximum consecutive transfers per grant (≥1)
- CNT_WIDTH, 16, width of the debug counters
- IDW, $clog2(NUM_REQ), owner index width (local)

- clk_i  in  1  single clock; the FIFO write clock
- rst_i  in  1  synchronous, active-high reset
- req_i  in  NUM_REQ  per-requester valid; held high with stable data until acked
- wdata_i  in  NUM_REQ*WIDTH  packed data; requester k uses bits [k*WIDTH +: WIDTH]
- full_i  in  1  FIFO full flag, write domain
- wr_error_i  in  1  FIFO write-error flag
- ack_o  out  NUM_REQ  one-hot (or zero); transfer occurs at a posedge where req_i[k] & ack_o[k]
- fifo_wr_en_o  out  1  FIFO write enable, equals |ack_o
- fifo_wdata_o  out  WIDTH  wdata of the acked requester; 0 when no ack
- owner_o  out  IDW  current/last owner index
- busy_o  out  1  high when the FSM is not IDLE
- xfer_cnt_o  out  CNT_WIDTH  total accepted writes, saturating
- err_cnt_o  out  CNT_WIDTH  cycles with wr_error_i high, saturating

## Operation
- Registered state: fsm (IDLE/BURST/HOLD), rr_ptr, owner, beat_cnt, xfer_cnt, err_cnt.
- ack_o, fifo_wr_en_o and fifo_wdata_o are combinational from the state, req_i and full_i. All are forced to 0 while rst_i=1.
- **Candidate** (IDLE only): the first index with req_i set, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ. Wrap is NUM_REQ-1 → 0.
- **IDLE**:
  - No req: stay in IDLE.
  - Candidate c exists and full_i=0: ack c, set owner=c, beat_cnt=1, go to BURST. If MAX_BURST=1, release instead.
  - Candidate exists and full_i=1: owner=c, beat_cnt=0, go to HOLD, no ack.
- **BURST**:
  - req_i[owner]=0: release, no write this cycle.
  - Else full_i=1: go to HOLD, no ack.
  - Else: ack owner, beat_cnt+1. If the new beat_cnt equals MAX_BURST, release (this beat is written).
- **HOLD**:
  - req_i[owner]=0: release.
  - Else full_i=0: ack owner, beat_cnt+1, then go to BURST, or release if MAX_BURST is reached.
  - Else stay in HOLD; beat_cnt is frozen.
- **Release**: fsm → IDLE, rr_ptr ← owner+1 (mod NUM_REQ). owner_o keeps the last owner.
- A non-owner's req_i is never acked. Requests from non-owners are only considered in IDLE.
- Counters:
  - xfer_cnt increments on every cycle with fifo_wr_en_o=1.
  - err_cnt increments on every cycle with wr_error_i=1, independent of acks.
  - Both saturate at 2^CNT_WIDTH-1.

## Timing
- Reset, effective at the first posedge with rst_i=1: fsm=IDLE, rr_ptr=0, owner_o=0, beat_cnt=0, busy_o=0, xfer_cnt_o=0, err_cnt_o=0. ack_o, fifo_wr_en_o and fifo_wdata_o are 0 combinationally for the whole time rst_i is high.
- Reset mid-burst: the burst is aborted with no further ack. After reset, priority restarts at index 0.
- Latency:
  - A request arriving in IDLE with the FIFO not full is acked in the same cycle.
  - The FIFO captures the data on the same posedge as the handshake (0 added cycles).
- Throughput:
  - One word per cycle, including across a max-length release: IDLE grants the next candidate in the cycle immediately after.
  - A release caused by a dropped req_i costs one bubble cycle.
- full_i is sampled combinationally in the same cycle, so no write is ever issued while full_i=1. wr_error_i is therefore expected to stay low.
- Simultaneous req and full in IDLE: the owner is chosen and goes to HOLD, so the grant is preserved for it.

## Test plan
All scenarios use NUM_REQ=4, WIDTH=8, MAX_BURST=4, and a FIFO of DEPTH 16.
- **Reset:** rst_i=1 for 2 cycles with req_i=4'b1111 → ack_o=0, fifo_wr_en_o=0, busy_o=0, owner_o=0, both counters 0. After release, the first ack goes to requester 0.
- **Single requester:** requester 1 alone sends 6 words (0x11..0x16).
  - Expect 6 consecutive writes: a burst of 4, then an immediate re-grant for 2.
  - owner_o=1, xfer_cnt_o=6, FIFO contents in order.
- **Fairness:** all four requesters continuously valid → ack order is 0×4, 1×4, 2×4, 3×4, then 0 again. Each owner receives exactly 4 beats; fifo_wr_en_o stays 1 until FIFO full.
- **Full stall:** requester 2 gets 2 beats, then full_i=1 for 3 cycles.
  - During full: fsm=HOLD, no ack, owner_o=2.
  - After full clears: 2 more beats for requester 2, then requester 3 is granted.
- **Early drop:** requester 0 drops req after 2 beats while requester 3 is waiting → one bubble cycle, then requester 3 is acked. rr_ptr skips requesters 1–2 because they are not requesting.
- **Errors and saturation:** pulse wr_error_i on 3 cycles, one coinciding with an ack → err_cnt_o=3. With CNT_WIDTH=4, 20 writes → xfer_cnt_o=15 (saturated).
